sge_share_arbiter: RTL

//   Time-shares one signed >= comparator (SInt sge) among NREQ requesters.

---
 rtl/sge_share_pkg.sv | 36 +++
 rtl/sint_sge_core.sv | 12 +
 rtl/sge_share_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/sge_share_pkg.sv
// Shared types and helpers for the time-shared signed >= comparator arbiter.
package sge_share_pkg;

    localparam int unsigned MAX_NREQ = 8;
    localparam int unsigned MAX_IDW  = 3;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // One-hot grant to the first valid lane at or after ptr, scanning upward modulo nreq.
    function automatic logic [MAX_NREQ-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] valid,
        input logic [MAX_IDW-1:0]  ptr,
        input int unsigned         nreq
    );
        logic [MAX_NREQ-1:0] onehot;
        logic                found;
        int unsigned         idx;
        onehot = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < MAX_NREQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            if (!found && (i < nreq) && valid[idx[MAX_IDW-1:0]]) begin
                onehot[idx[MAX_IDW-1:0]] = 1'b1;
                found                    = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/sint_sge_core.sv
// Combinational full-width two's-complement lhs >= rhs.
module sint_sge_core #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    output logic             ge_c
);

    assign ge_c = ($signed(lhs) >= $signed(rhs));

endmodule

// File: rtl/sge_share_arbiter.sv
// Round-robin arbiter sharing one signed >= comparator among NREQ lanes,
// with a one-entry tagged result register.
module sge_share_arbiter
    import sge_share_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned NREQ  = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_in0,
    input  logic [NREQ*WIDTH-1:0]   req_in1,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    rsp_out,
    output logic                    busy
);

    localparam int unsigned IDW = $clog2(NREQ);

    rsp_state_e          state_q;
    rsp_state_e          state_d;
    logic [IDW-1:0]      ptr_q;
    logic [IDW-1:0]      ptr_d;
    logic [IDW-1:0]      rsp_id_q;
    logic                rsp_out_q;
    logic                can_accept;
    logic [MAX_NREQ-1:0] grant_full;
    logic [NREQ-1:0]     grant;
    logic                any_grant;
    logic                load_rsp;
    logic [IDW-1:0]      gidx;
    logic [WIDTH-1:0]    lhs;
    logic [WIDTH-1:0]    rhs;
    logic                ge;
    logic                unused_grant;

    assign rsp_valid  = (state_q == RSP_FULL);
    assign rsp_id     = rsp_id_q;
    assign rsp_out    = rsp_out_q;
    assign busy       = rsp_valid | (|req_valid);
    assign can_accept = !rsp_valid || rsp_ready;

    assign grant_full   = rr_pick(MAX_NREQ'(req_valid), MAX_IDW'(ptr_q), NREQ);
    assign unused_grant = ^grant_full;

    // Trim the package-width grant to NREQ lanes and select the granted operands.
    always_comb begin
        grant = '0;
        gidx  = '0;
        lhs   = '0;
        rhs   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant[i] = grant_full[i];
            if (grant_full[i]) begin
                gidx = IDW'(i);
                lhs  = req_in0[i*WIDTH +: WIDTH];
                rhs  = req_in1[i*WIDTH +: WIDTH];
            end
        end
    end

    assign req_ready = (can_accept && !RESET) ? grant : '0;
    assign any_grant = |req_ready;

    sint_sge_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .lhs  (lhs),
        .rhs  (rhs),
        .ge_c (ge)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RSP_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Result register occupancy, pointer advance and result capture.
    always_comb begin
        state_d  = state_q;
        load_rsp = 1'b0;
        ptr_d    = ptr_q;
        if (any_grant) begin
            load_rsp = 1'b1;
            ptr_d    = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
        end
        case (state_q)
            RSP_EMPTY: if (any_grant) state_d = RSP_FULL;
            RSP_FULL:  if (rsp_ready && !any_grant) state_d = RSP_EMPTY;
            default:   state_d = RSP_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_q     <= '0;
            rsp_id_q  <= '0;
            rsp_out_q <= 1'b0;
        end else if (load_rsp) begin
            ptr_q     <= ptr_d;
            rsp_id_q  <= gidx;
            rsp_out_q <= ge;
        end
    end

endmodule
